// File: rtl/ram_clear_pkg.sv
// Shared types and helpers for the SDRAM/DDR3 power-up clear sequencer.
package ram_clear_pkg;

   // SDRAM channel: one write strobe per word, then wait for the controller.
   typedef enum logic [1:0] {
      SdrIdle,
      SdrIssue,
      SdrWait,
      SdrDone
   } sdr_state_t;

   // DDR3 channel: back-to-back Avalon bursts until the top burst completes.
   typedef enum logic [1:0] {
      DdrIdle,
      DdrBurst,
      DdrDone
   } ddr_state_t;

   // Beat counter width; a one-beat burst still needs a 1-bit counter.
   function automatic int unsigned beat_w(input int unsigned burst);
      return (burst <= 1) ? 1 : $clog2(burst);
   endfunction

endpackage

// File: rtl/ram_clear_seq_ddr_burst_writer.sv
// DDR3 channel of the clear sequencer: Avalon-MM burst writer filling the
// whole beat-address space with a constant pattern.
module ddr_burst_writer #(
   parameter int unsigned DDR_AW = 28,
   parameter int unsigned BURST  = 8,
   parameter logic [15:0] FILL   = 16'h0000
) (
   input  logic              clk_sys,
   input  logic              RESET,
   input  logic              start,
   input  logic              ddr_busy,
   output logic [DDR_AW-1:0] ddr_addr,
   output logic [7:0]        ddr_burstcnt,
   output logic [63:0]       ddr_din,
   output logic [7:0]        ddr_be,
   output logic              ddr_we,
   output logic              ddr_done
);
   import ram_clear_pkg::*;

   localparam int unsigned       BW        = beat_w(BURST);
   localparam logic [BW-1:0]     BEAT_LAST = BW'(BURST - 1);
   localparam logic [DDR_AW-1:0] ADDR_STEP = DDR_AW'(BURST);
   // Start address of the final burst: 2^DDR_AW - BURST.
   localparam logic [DDR_AW-1:0] ADDR_LAST = ~DDR_AW'(BURST - 1);

   ddr_state_t        state;
   logic [DDR_AW-1:0] addr_q;
   logic [BW-1:0]     beat_q;
   logic              we_q;

   // Burst FSM: address held for a whole burst, advanced only on its last accepted beat.
   always_ff @(posedge clk_sys) begin
      if (!RESET || start) begin
         state  <= DdrIdle;
         addr_q <= '0;
         beat_q <= '0;
         we_q   <= 1'b0;
      end else begin
         case (state)
            DdrIdle: begin
               state  <= DdrBurst;
               beat_q <= '0;
               we_q   <= 1'b1;
            end
            DdrBurst: begin
               if (!ddr_busy) begin
                  if (beat_q == BEAT_LAST) begin
                     beat_q <= '0;
                     if (addr_q == ADDR_LAST) begin
                        state <= DdrDone;
                        we_q  <= 1'b0;
                     end else begin
                        addr_q <= addr_q + ADDR_STEP;
                     end
                  end else begin
                     beat_q <= beat_q + BW'(1);
                  end
               end
            end
            DdrDone: begin
               we_q <= 1'b0;
            end
            default: begin
               state <= DdrIdle;
               we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ddr_addr     = addr_q;
   assign ddr_we       = we_q;
   assign ddr_done     = (state == DdrDone);
   assign ddr_burstcnt = 8'(BURST);
   assign ddr_din      = {4{FILL}};
   assign ddr_be       = 8'hFF;

endmodule

// File: rtl/ram_clear_seq.sv
// Power-up / on-request zero-fill sequencer for SDRAM and DDR3. The SDRAM
// channel lives here; the DDR3 channel is a separate burst writer.
module ram_clear_seq #(
   parameter int unsigned SDR_AW = 25,
   parameter int unsigned DDR_AW = 28,
   parameter int unsigned BURST  = 8,
   parameter logic [15:0] FILL   = 16'h0000
) (
   input  logic              clk_sys,
   input  logic              RESET,
   input  logic              start,
   output logic [SDR_AW-1:0] sdr_addr,
   output logic [15:0]       sdr_din,
   output logic              sdr_we,
   input  logic              sdr_ready,
   output logic [DDR_AW-1:0] ddr_addr,
   output logic [7:0]        ddr_burstcnt,
   output logic [63:0]       ddr_din,
   output logic [7:0]        ddr_be,
   output logic              ddr_we,
   input  logic              ddr_busy,
   output logic [7:0]        progress,
   output logic              done
);
   import ram_clear_pkg::*;

   sdr_state_t        sdr_state;
   logic [SDR_AW-1:0] sdr_addr_q;
   logic              sdr_we_q;
   logic              done_q;
   logic              ddr_done;

   // SDRAM FSM: strobe one word, then wait for ready before moving to the next.
   always_ff @(posedge clk_sys) begin
      if (!RESET || start) begin
         sdr_state  <= SdrIdle;
         sdr_addr_q <= '0;
         sdr_we_q   <= 1'b0;
      end else begin
         case (sdr_state)
            SdrIdle: begin
               sdr_state <= SdrIssue;
               sdr_we_q  <= 1'b1;
            end
            SdrIssue: begin
               // ready is deliberately ignored here; it refers to the previous access
               sdr_state <= SdrWait;
               sdr_we_q  <= 1'b0;
            end
            SdrWait: begin
               if (sdr_ready) begin
                  if (&sdr_addr_q) begin
                     sdr_state <= SdrDone;
                  end else begin
                     sdr_addr_q <= sdr_addr_q + SDR_AW'(1);
                     sdr_state  <= SdrIssue;
                     sdr_we_q   <= 1'b1;
                  end
               end
            end
            SdrDone: begin
               sdr_we_q <= 1'b0;
            end
            default: begin
               sdr_state <= SdrIdle;
               sdr_we_q  <= 1'b0;
            end
         endcase
      end
   end

   // Completion flag, one cycle behind the later channel reaching its DONE state.
   always_ff @(posedge clk_sys) begin
      if (!RESET || start) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (sdr_state == SdrDone) && ddr_done;
      end
   end

   ddr_burst_writer #(
      .DDR_AW (DDR_AW),
      .BURST  (BURST),
      .FILL   (FILL)
   ) u_ddr (
      .clk_sys      (clk_sys),
      .RESET        (RESET),
      .start        (start),
      .ddr_busy     (ddr_busy),
      .ddr_addr     (ddr_addr),
      .ddr_burstcnt (ddr_burstcnt),
      .ddr_din      (ddr_din),
      .ddr_be       (ddr_be),
      .ddr_we       (ddr_we),
      .ddr_done     (ddr_done)
   );

   // Narrow address spaces are left-aligned so progress still reads as a fraction of 256.
   if (SDR_AW >= 8) begin : g_prog_wide
      assign progress = sdr_addr_q[SDR_AW-1 -: 8];
   end else begin : g_prog_narrow
      assign progress = {sdr_addr_q, {(8 - SDR_AW){1'b0}}};
   end

   assign sdr_addr = sdr_addr_q;
   assign sdr_we   = sdr_we_q;
   assign sdr_din  = FILL;
   assign done     = done_q;

endmodule

// File: tb/tb_ram_clear_seq.sv
// Directed bench for ram_clear_seq with a small address space.
module tb_ram_clear_seq;

   localparam int unsigned SDR_AW   = 4;
   localparam int unsigned DDR_AW   = 6;
   localparam int unsigned BURST    = 4;
   localparam logic [15:0] FILL     = 16'hA5C3;
   localparam logic [63:0] DDR_FILL = {4{FILL}};

   logic              clk_sys = 1'b0;
   logic              RESET;
   logic              start;
   logic [SDR_AW-1:0] sdr_addr;
   logic [15:0]       sdr_din;
   logic              sdr_we;
   logic              sdr_ready;
   logic [DDR_AW-1:0] ddr_addr;
   logic [7:0]        ddr_burstcnt;
   logic [63:0]       ddr_din;
   logic [7:0]        ddr_be;
   logic              ddr_we;
   logic              ddr_busy;
   logic [7:0]        progress;
   logic              done;

   int vectors     = 0;
   int miscompares = 0;

   // Monitor state, cleared while mon_clr is high.
   logic              mon_clr   = 1'b1;
   logic              rand_busy = 1'b0;
   int                sdr_pulses, sdr_seq_err, sdr_b2b;
   int                ddr_beats, ddr_seq_err, stall_err;
   logic              prev_sdr_we, prev_stall;
   logic [DDR_AW-1:0] prev_ddr_addr;

   ram_clear_seq #(
      .SDR_AW (SDR_AW),
      .DDR_AW (DDR_AW),
      .BURST  (BURST),
      .FILL   (FILL)
   ) dut (
      .clk_sys      (clk_sys),
      .RESET        (RESET),
      .start        (start),
      .sdr_addr     (sdr_addr),
      .sdr_din      (sdr_din),
      .sdr_we       (sdr_we),
      .sdr_ready    (sdr_ready),
      .ddr_addr     (ddr_addr),
      .ddr_burstcnt (ddr_burstcnt),
      .ddr_din      (ddr_din),
      .ddr_be       (ddr_be),
      .ddr_we       (ddr_we),
      .ddr_busy     (ddr_busy),
      .progress     (progress),
      .done         (done)
   );

   always #5 clk_sys = ~clk_sys;

   // Collect strobe/beat statistics on the falling edge, away from DUT updates.
   always @(negedge clk_sys) begin
      if (mon_clr) begin
         sdr_pulses    = 0;
         sdr_seq_err   = 0;
         sdr_b2b       = 0;
         ddr_beats     = 0;
         ddr_seq_err   = 0;
         stall_err     = 0;
         prev_sdr_we   = 1'b0;
         prev_stall    = 1'b0;
         prev_ddr_addr = '0;
      end else begin
         if (sdr_we) begin
            if (sdr_addr !== 4'(sdr_pulses) || sdr_din !== FILL) sdr_seq_err++;
            if (prev_sdr_we) sdr_b2b++;
            sdr_pulses++;
         end
         if (prev_stall && (ddr_we !== 1'b1 || ddr_addr !== prev_ddr_addr ||
                            ddr_din !== DDR_FILL))
            stall_err++;
         if (ddr_we && !ddr_busy) begin
            if (ddr_addr !== 6'((ddr_beats / 4) * 4)) ddr_seq_err++;
            ddr_beats++;
         end
         prev_sdr_we   = sdr_we;
         prev_stall    = ddr_we && ddr_busy;
         prev_ddr_addr = ddr_addr;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag, input int limit);
      int n = 0;
      while (!done && n < limit) begin
         if (rand_busy) ddr_busy = 1'($urandom_range(0, 1));
         tick(1);
         n++;
      end
      ddr_busy = 1'b0;
      check(tag, 64'(done), 64'd1);
   endtask

   task automatic restart();
      start   = 1'b1;
      mon_clr = 1'b1;
      tick(1);
      check("start_sdr_addr", 64'(sdr_addr), 64'd0);
      check("start_ddr_addr", 64'(ddr_addr), 64'd0);
      check("start_done", 64'(done), 64'd0);
      check("start_we", {62'd0, sdr_we, ddr_we}, 64'd0);
      start   = 1'b0;
      mon_clr = 1'b0;
   endtask

   task automatic check_full_pass(input string tag);
      check({tag, "_sdr_pulses"}, 64'(sdr_pulses), 64'd16);
      check({tag, "_sdr_seq"}, 64'(sdr_seq_err + sdr_b2b), 64'd0);
      check({tag, "_ddr_beats"}, 64'(ddr_beats), 64'd64);
      check({tag, "_ddr_seq"}, 64'(ddr_seq_err + stall_err), 64'd0);
      check({tag, "_progress"}, 64'(progress), 64'hF0);
   endtask

   initial begin
      int n_we;
      RESET     = 1'b0;
      start     = 1'b0;
      sdr_ready = 1'b1;
      ddr_busy  = 1'b0;

      // Reset values and constant outputs.
      tick(3);
      check("rst_sdr_we", 64'(sdr_we), 64'd0);
      check("rst_ddr_we", 64'(ddr_we), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sdr_addr", 64'(sdr_addr), 64'd0);
      check("rst_ddr_addr", 64'(ddr_addr), 64'd0);
      check("rst_progress", 64'(progress), 64'd0);
      check("const_burstcnt", 64'(ddr_burstcnt), 64'd4);
      check("const_be", 64'(ddr_be), 64'hFF);
      check("const_sdr_din", 64'(sdr_din), 64'hA5C3);
      check("const_ddr_din", ddr_din, 64'hA5C3A5C3A5C3A5C3);

      // Full pass, ready tied high and no waitrequest.
      RESET   = 1'b1;
      mon_clr = 1'b0;
      tick(1);
      check("c1_sdr_we", 64'(sdr_we), 64'd1);
      check("c1_ddr_we", 64'(ddr_we), 64'd1);
      check("c1_addrs", {32'(sdr_addr), 32'(ddr_addr)}, 64'd0);
      tick(1);
      check("c2_sdr_we", 64'(sdr_we), 64'd0);
      wait_done("p1_done", 300);
      check_full_pass("p1");
      tick(5);
      check("p1_done_hold", 64'(done), 64'd1);
      check("p1_we_idle", {62'd0, sdr_we, ddr_we}, 64'd0);
      check("p1_no_extra", 64'(ddr_beats), 64'd64);

      // Random waitrequest on the DDR3 side.
      rand_busy = 1'b1;
      restart();
      wait_done("rb_done", 1000);
      check_full_pass("rb");
      repeat (8) begin
         ddr_busy = 1'($urandom_range(0, 1));
         tick(1);
      end
      ddr_busy  = 1'b0;
      rand_busy = 1'b0;
      check("rb_no_extra", 64'(ddr_beats), 64'd64);

      // SDRAM controller not ready after the first strobe.
      sdr_ready = 1'b0;
      restart();
      tick(1);
      check("nr_first_we", 64'(sdr_we), 64'd1);
      n_we = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (sdr_we) n_we++;
      end
      check("nr_no_second_we", 64'(n_we), 64'd0);
      check("nr_addr_held", 64'(sdr_addr), 64'd0);
      sdr_ready = 1'b1;
      tick(1);
      check("nr_resume_we", 64'(sdr_we), 64'd1);
      check("nr_resume_addr", 64'(sdr_addr), 64'd1);
      wait_done("nr_done", 300);
      check_full_pass("nr");

      // start mid-run: sdr_addr 7 issue cycle, DDR in the middle of burst at 12.
      restart();
      for (int i = 0; i < 50 && !(sdr_we && sdr_addr == 4'd7); i++) tick(1);
      check("mid_sdr_addr", 64'(sdr_addr), 64'd7);
      check("mid_ddr_addr", 64'(ddr_addr), 64'd12);
      check("mid_ddr_we", 64'(ddr_we), 64'd1);
      restart();
      wait_done("mid_done", 300);
      check_full_pass("mid");

      // Reset during a DDR burst.
      restart();
      tick(10);
      check("rb2_ddr_we", 64'(ddr_we), 64'd1);
      check("rb2_ddr_addr", 64'(ddr_addr), 64'd8);
      RESET   = 1'b0;
      mon_clr = 1'b1;
      tick(1);
      check("rmid_we", {62'd0, sdr_we, ddr_we}, 64'd0);
      check("rmid_addrs", {32'(sdr_addr), 32'(ddr_addr)}, 64'd0);
      check("rmid_done", 64'(done), 64'd0);
      RESET   = 1'b1;
      mon_clr = 1'b0;
      tick(1);
      check("rmid_restart_we", {62'd0, sdr_we, ddr_we}, 64'd3);
      wait_done("rmid_done2", 300);
      check_full_pass("rmid");

      // start together with reset: reset values, start has no extra effect.
      RESET   = 1'b0;
      start   = 1'b1;
      mon_clr = 1'b1;
      tick(1);
      check("rs_done", 64'(done), 64'd0);
      check("rs_we", {62'd0, sdr_we, ddr_we}, 64'd0);
      check("rs_addrs", {32'(sdr_addr), 32'(ddr_addr)}, 64'd0);
      start = 1'b0;
      tick(1);
      check("rs_hold_we", {62'd0, sdr_we, ddr_we}, 64'd0);
      RESET   = 1'b1;
      mon_clr = 1'b0;
      tick(1);
      check("rs_release_we", {62'd0, sdr_we, ddr_we}, 64'd3);
      check("rs_release_addr", {32'(sdr_addr), 32'(ddr_addr)}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
